// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants for the D-stage branch hazard scheduler:
// forwarding select encodings and the Tuse/Tnew classes of the ISA.
package branch_hazard_ctrl_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned TW_DEF   = 2;
    localparam int unsigned CNTW_DEF = 32;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_E  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // Cycles until the consumer needs the operand, counted from D
    localparam logic [TW_DEF-1:0] TUSE_BR  = 2'd0;
    localparam logic [TW_DEF-1:0] TUSE_ALU = 2'd1;
    localparam logic [TW_DEF-1:0] TUSE_ST  = 2'd2;

    // Cycles after E entry until the producer's result exists
    localparam logic [TW_DEF-1:0] TNEW_LINK = 2'd0;
    localparam logic [TW_DEF-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW_DEF-1:0] TNEW_LD   = 2'd2;

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// D-stage request and hazard-decision bundle between the decode stage
// (master) and the hazard scheduler (slave).
interface branch_hazard_ctrl_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned TW   = 2,
    parameter int unsigned CNTW = 32
) ();

    logic            d_valid;
    logic            d_branch;
    logic [AW-1:0]   d_rs;
    logic [AW-1:0]   d_rt;
    logic [TW-1:0]   d_tuse_rs;
    logic [TW-1:0]   d_tuse_rt;
    logic [AW-1:0]   d_wa;
    logic [TW-1:0]   d_tnew;
    logic            ext_stall;
    logic            flush;

    logic            stall;
    logic [1:0]      fwd_rs;
    logic [1:0]      fwd_rt;
    logic            cmp_en;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output d_valid, d_branch, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wa, d_tnew, ext_stall, flush,
        input  stall, fwd_rs, fwd_rt, cmp_en, stall_cnt
    );

    modport slave (
        input  d_valid, d_branch, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_wa, d_tnew, ext_stall, flush,
        output stall, fwd_rs, fwd_rt, cmp_en, stall_cnt
    );

endinterface

// File: rtl/branch_hazard_ctrl_hazard_slot_match.sv
// Per-source hazard evaluation against the E and M shadow slots:
// decides whether this operand forces a stall and where it is forwarded from.
module hazard_slot_match
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
) (
    input  logic [AW-1:0] src,
    input  logic [TW-1:0] tuse,
    input  logic          e_valid,
    input  logic [AW-1:0] e_wa,
    input  logic [TW-1:0] e_tnew,
    input  logic          m_valid,
    input  logic [AW-1:0] m_wa,
    input  logic [TW-1:0] m_tnew,
    output logic          stall_c,
    output fwd_sel_e      fwd_c
);

    logic e_hit;
    logic m_hit;

    // $0 is hard-wired, so it never matches an in-flight writer
    assign e_hit = e_valid && (src != '0) && (src == e_wa);
    assign m_hit = m_valid && (src != '0) && (src == m_wa);

    always_comb begin : eval
        stall_c = 1'b0;
        fwd_c   = FWD_RF;
        if ((e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse))) begin
            stall_c = 1'b1;
        end
        // Youngest ready writer wins; W is covered by the write-through regfile
        if (e_hit && (e_tnew == '0)) begin
            fwd_c = FWD_E;
        end else if (m_hit && (m_tnew == '0)) begin
            fwd_c = FWD_M;
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// D-stage hazard scheduler: tracks in-flight writers in E and M, derives
// stall/forwarding for both D operands and counts stall cycles.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned TW   = TW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_hazard_ctrl_if.slave  bus
);

    logic            e_valid;
    logic [AW-1:0]   e_wa;
    logic [TW-1:0]   e_tnew;
    logic            m_valid;
    logic [AW-1:0]   m_wa;
    logic [TW-1:0]   m_tnew;
    logic [CNTW-1:0] stall_cnt_q;

    logic            rs_stall;
    logic            rt_stall;
    fwd_sel_e        rs_fwd;
    fwd_sel_e        rt_fwd;
    logic            stall_c;
    logic            issue_c;

    hazard_slot_match #(.AW(AW), .TW(TW)) u_rs_match (
        .src     (bus.d_rs),
        .tuse    (bus.d_tuse_rs),
        .e_valid (e_valid),
        .e_wa    (e_wa),
        .e_tnew  (e_tnew),
        .m_valid (m_valid),
        .m_wa    (m_wa),
        .m_tnew  (m_tnew),
        .stall_c (rs_stall),
        .fwd_c   (rs_fwd)
    );

    hazard_slot_match #(.AW(AW), .TW(TW)) u_rt_match (
        .src     (bus.d_rt),
        .tuse    (bus.d_tuse_rt),
        .e_valid (e_valid),
        .e_wa    (e_wa),
        .e_tnew  (e_tnew),
        .m_valid (m_valid),
        .m_wa    (m_wa),
        .m_tnew  (m_tnew),
        .stall_c (rt_stall),
        .fwd_c   (rt_fwd)
    );

    // Decision outputs are combinational so the stall takes effect this cycle
    always_comb begin : decide
        stall_c = ~reset & bus.d_valid & (rs_stall | rt_stall);
        issue_c = bus.d_valid & ~stall_c & ~bus.ext_stall;
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_rs    = reset ? FWD_RF : rs_fwd;
    assign bus.fwd_rt    = reset ? FWD_RF : rt_fwd;
    assign bus.cmp_en    = ~reset & bus.d_valid & bus.d_branch & ~stall_c
                         & ~bus.ext_stall & ~bus.flush;
    assign bus.stall_cnt = stall_cnt_q;

    // Shadow E/M slots: flush kills both, ext_stall freezes both
    always_ff @(posedge clk or posedge reset) begin : slot_pipe
        if (reset) begin
            e_valid <= 1'b0;
            e_wa    <= '0;
            e_tnew  <= '0;
            m_valid <= 1'b0;
            m_wa    <= '0;
            m_tnew  <= '0;
        end else if (bus.flush) begin
            e_valid <= 1'b0;
            e_wa    <= '0;
            e_tnew  <= '0;
            m_valid <= 1'b0;
            m_wa    <= '0;
            m_tnew  <= '0;
        end else if (!bus.ext_stall) begin
            m_valid <= e_valid;
            m_wa    <= e_wa;
            m_tnew  <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
            if (issue_c) begin
                e_valid <= (bus.d_wa != '0);
                e_wa    <= bus.d_wa;
                e_tnew  <= bus.d_tnew;
            end else begin
                e_valid <= 1'b0;
                e_wa    <= '0;
                e_tnew  <= '0;
            end
        end
    end

    // Saturating count of cycles actually lost to hazard stalls
    always_ff @(posedge clk or posedge reset) begin : stall_counter
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_c && !bus.ext_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed pipeline scenarios
// with literal expectations, then randomized traffic against an in-flight model.
module tb_branch_hazard_ctrl;
    import branch_hazard_ctrl_pkg::*;

    localparam int unsigned AW   = 5;
    localparam int unsigned TW   = 2;
    localparam int unsigned CNTW = 6;
    localparam int          CNT_MAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.AW(AW), .TW(TW), .CNTW(CNTW)) bif ();

    branch_hazard_ctrl #(.AW(AW), .TW(TW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // In-flight writers: index 0 is in E, index 1 is in M; tnew as issued
    bit s_valid [2];
    int s_wa    [2];
    int s_tnew  [2];
    int cnt_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int remaining(int i);
        return (s_tnew[i] > i) ? s_tnew[i] - i : 0;
    endfunction

    function automatic bit writes(int i, int src);
        return s_valid[i] && (src != 0) && (src == s_wa[i]);
    endfunction

    function automatic bit src_blocks(int src, int tuse);
        for (int i = 0; i < 2; i++)
            if (writes(i, src) && remaining(i) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int src_fwd(int src);
        for (int i = 0; i < 2; i++)
            if (writes(i, src) && remaining(i) == 0) return (i == 0) ? 1 : 2;
        return 0;
    endfunction

    function automatic bit exp_stall();
        return !reset && bif.d_valid &&
               (src_blocks(int'(bif.d_rs), int'(bif.d_tuse_rs)) ||
                src_blocks(int'(bif.d_rt), int'(bif.d_tuse_rt)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_wa[i]    = 0;
            s_tnew[i]  = 0;
        end
        cnt_m = 0;
    endtask

    task automatic drive(input bit dv, input bit br, input int rs, input int rt,
                         input int tr, input int tt, input int wa, input int tn,
                         input bit ext, input bit fl);
        bif.d_valid   = dv;
        bif.d_branch  = br;
        bif.d_rs      = AW'(rs);
        bif.d_rt      = AW'(rt);
        bif.d_tuse_rs = TW'(tr);
        bif.d_tuse_rt = TW'(tt);
        bif.d_wa      = AW'(wa);
        bif.d_tnew    = TW'(tn);
        bif.ext_stall = ext;
        bif.flush     = fl;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Compare every output against the model in the middle of the cycle
    task automatic check_model();
        bit es;
        bit ec;
        es = exp_stall();
        ec = !reset && bif.d_valid && bif.d_branch && !es && !bif.ext_stall && !bif.flush;
        chk("stall",     32'(bif.stall),     32'(es));
        chk("fwd_rs",    32'(bif.fwd_rs),    reset ? 32'd0 : 32'(src_fwd(int'(bif.d_rs))));
        chk("fwd_rt",    32'(bif.fwd_rt),    reset ? 32'd0 : 32'(src_fwd(int'(bif.d_rt))));
        chk("cmp_en",    32'(bif.cmp_en),    32'(ec));
        chk("stall_cnt", 32'(bif.stall_cnt), 32'(cnt_m));
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        bit es;
        bit iss;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            es  = exp_stall();
            iss = bif.d_valid && !es && !bif.ext_stall;
            if (es && !bif.ext_stall && cnt_m < CNT_MAX) cnt_m++;
            if (bif.flush) begin
                s_valid[0] = 1'b0;
                s_valid[1] = 1'b0;
            end else if (!bif.ext_stall) begin
                s_valid[1] = s_valid[0];
                s_wa[1]    = s_wa[0];
                s_tnew[1]  = s_tnew[0];
                s_valid[0] = iss && (bif.d_wa != '0);
                s_wa[0]    = int'(bif.d_wa);
                s_tnew[0]  = int'(bif.d_tnew);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2; k++) begin
            nop();
            sample();
            advance();
        end
    endtask

    task automatic issue_lw8();
        drive(1'b1, 1'b0, 0, 0, int'(TUSE_ALU), int'(TUSE_ST), 8, int'(TNEW_LD), 1'b0, 1'b0);
        sample();
        advance();
    endtask

    initial begin
        int regs [5];
        regs[0] = 0; regs[1] = 1; regs[2] = 2; regs[3] = 3; regs[4] = 31;

        // Reset held: outputs quiet even with a branch presented
        reset = 1'b1;
        model_reset();
        drive(1'b1, 1'b1, 8, 9, 0, 0, 8, 2, 1'b0, 1'b0);
        sample();
        chk("rst_stall", 32'(bif.stall), 32'd0);
        chk("rst_cmp_en", 32'(bif.cmp_en), 32'd0);
        chk("rst_cnt", 32'(bif.stall_cnt), 32'd0);
        advance();
        reset = 1'b0;
        drain();

        // lw $8 then beq $8,$9: two stalls, then regfile (lw reached W)
        issue_lw8();
        drive(1'b1, 1'b1, 8, 9, int'(TUSE_BR), int'(TUSE_BR), 0, 0, 1'b0, 1'b0);
        sample(); chk("ld_br_stall1", 32'(bif.stall), 32'd1); chk("ld_br_cmp1", 32'(bif.cmp_en), 32'd0);
        advance();
        sample(); chk("ld_br_stall2", 32'(bif.stall), 32'd1);
        advance();
        sample(); chk("ld_br_go", 32'(bif.stall), 32'd0); chk("ld_br_fwd", 32'(bif.fwd_rs), 32'd0);
        chk("ld_br_cmp", 32'(bif.cmp_en), 32'd1); chk("ld_br_cnt", 32'(bif.stall_cnt), 32'd2);
        advance();
        drain();

        // addu $3 then bne $3,$0: one stall then forward from M
        drive(1'b1, 1'b0, 1, 2, 1, 1, 3, int'(TNEW_ALU), 1'b0, 1'b0);
        sample(); advance();
        drive(1'b1, 1'b1, 3, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("alu_br_stall", 32'(bif.stall), 32'd1);
        advance();
        sample(); chk("alu_br_go", 32'(bif.stall), 32'd0);
        chk("alu_br_fwd_rs", 32'(bif.fwd_rs), 32'(FWD_M)); chk("alu_br_fwd_rt", 32'(bif.fwd_rt), 32'(FWD_RF));
        advance();
        drain();

        // jal then beq $31,$2: forward from E immediately
        drive(1'b1, 1'b0, 0, 0, 1, 1, 31, int'(TNEW_LINK), 1'b0, 1'b0);
        sample(); advance();
        drive(1'b1, 1'b1, 31, 2, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("jal_br_stall", 32'(bif.stall), 32'd0); chk("jal_br_fwd", 32'(bif.fwd_rs), 32'(FWD_E));
        advance();
        drain();

        // Writes to $0 never create hazards
        drive(1'b1, 1'b0, 0, 0, 1, 1, 0, 2, 1'b0, 1'b0);
        sample(); advance();
        drive(1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("zero_stall", 32'(bif.stall), 32'd0); chk("zero_fwd", 32'(bif.fwd_rs), 32'd0);
        advance();
        drain();

        // E and M both write $5 with E ready: E wins
        drive(1'b1, 1'b0, 0, 0, 1, 1, 5, 1, 1'b0, 1'b0);
        sample(); advance();
        drive(1'b1, 1'b0, 0, 0, 1, 1, 5, 0, 1'b0, 1'b0);
        sample(); advance();
        drive(1'b1, 1'b1, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("prio_fwd", 32'(bif.fwd_rs), 32'(FWD_E)); chk("prio_stall", 32'(bif.stall), 32'd0);
        advance();
        drain();

        // ext_stall freezes the load hazard; two stalls still owed afterwards
        issue_lw8();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 8, 9, 0, 0, 0, 0, 1'b1, 1'b0);
            sample(); chk("ext_stall", 32'(bif.stall), 32'd1); chk("ext_cnt", 32'(bif.stall_cnt), 32'd3);
            advance();
        end
        drive(1'b1, 1'b1, 8, 9, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("ext_rel1", 32'(bif.stall), 32'd1);
        advance();
        sample(); chk("ext_rel2", 32'(bif.stall), 32'd1);
        advance();
        sample(); chk("ext_go", 32'(bif.stall), 32'd0); chk("ext_cnt_end", 32'(bif.stall_cnt), 32'd5);
        advance();
        drain();

        // flush kills lw $8 in E; the following beq $8 proceeds
        issue_lw8();
        drive(1'b1, 1'b1, 1, 2, 0, 0, 0, 0, 1'b0, 1'b1);
        sample(); chk("flush_cmp", 32'(bif.cmp_en), 32'd0);
        advance();
        drive(1'b1, 1'b1, 8, 9, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("flush_stall", 32'(bif.stall), 32'd0); chk("flush_cmp_after", 32'(bif.cmp_en), 32'd1);
        advance();
        drain();

        // Async reset in the middle of a stall
        issue_lw8();
        drive(1'b1, 1'b1, 8, 9, 0, 0, 0, 0, 1'b0, 1'b0);
        sample(); chk("mid_pre", 32'(bif.stall), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_stall", 32'(bif.stall), 32'd0);
        chk("mid_rst_cnt", 32'(bif.stall_cnt), 32'd0);
        advance();
        reset = 1'b0;
        drain();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(399, 0) == 0);
            if (reset) model_reset();
            drive($urandom_range(9, 0) < 8, $urandom_range(9, 0) < 4,
                  regs[$urandom_range(4, 0)], regs[$urandom_range(4, 0)],
                  int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                  regs[$urandom_range(4, 0)], int'($urandom_range(2, 0)),
                  $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0);
            sample();
            advance();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
